// File: rtl/weight_fifo_pkg.sv
// weight_fifo_pkg: shared width helpers for the weight-tile FIFO.
//   tile_width  - bits in one tile (weight width * PE rows * weights per row)
//   ptr_width   - memory address width for a given depth
//   count_width - width able to hold 0..depth+1 (memory plus output register)
package weight_fifo_pkg;

    function automatic int unsigned tile_width(input int unsigned weight_bw,
                                               input int unsigned num_rows,
                                               input int unsigned matrix_size);
        return weight_bw * num_rows * matrix_size;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/weight_tile_fifo_if.sv
// weight_tile_fifo_if: write and read valid/ready handshakes of the weight-tile FIFO.
//   wr_valid/wr_ready/wr_data           - producer side (weight memory)
//   rd_valid/rd_ready/rd_data/rd_last   - consumer side (PE array)
// slave is the FIFO's view, master the view of whoever drives both handshakes.
interface weight_tile_fifo_if #(
    parameter int unsigned TILE_W = 512
);
    logic              wr_valid;
    logic              wr_ready;
    logic [TILE_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_last;
    logic [TILE_W-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/weight_fifo_mem.sv
// weight_fifo_mem: simple dual-port tile store.
//   clk, rst                   - clock, async active-high reset (read register only)
//   wr_en, wr_addr, wr_data    - write port
//   rd_en, rd_addr, rd_data    - synchronous read port; rd_data holds while rd_en is low,
//                                so it doubles as the FIFO's output register
module weight_fifo_mem #(
    parameter int unsigned WIDTH  = 512,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Data array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/weight_tile_fifo.sv
// weight_tile_fifo: weight-tile buffer with show-ahead output register and per-tile reuse.
//   clk, rst     - clock, async active-high reset
//   flush        - synchronous clear of all held tiles
//   reuse_num    - deliveries per tile, sampled when a tile enters the output register (0 -> 1)
//   bus          - write/read handshakes (slave modport)
//   count        - tiles held in memory plus output register (registered)
//   almost_full  - count >= AFULL_TH (registered)
module weight_tile_fifo
    import weight_fifo_pkg::*;
#(
    parameter int unsigned WEIGHT_BW   = 8,
    parameter int unsigned NUM_PE_ROWS = 8,
    parameter int unsigned MATRIX_SIZE = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned AFULL_TH    = 4,
    parameter int unsigned REUSE_BW    = 4,
    localparam int unsigned TILE_W     = tile_width(WEIGHT_BW, NUM_PE_ROWS, MATRIX_SIZE),
    localparam int unsigned CNT_W      = count_width(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [REUSE_BW-1:0] reuse_num,
    weight_tile_fifo_if.slave   bus,
    output logic [CNT_W-1:0]    count,
    output logic                almost_full
);
    localparam int unsigned         PTR_W    = ptr_width(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]    AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [REUSE_BW-1:0] ONE_R    = REUSE_BW'(1);

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    mem_count_q, mem_count_d, count_q, count_d;
    logic [REUSE_BW-1:0] rem_q, rem_d;
    logic                rd_valid_q, rd_valid_d, almost_full_q;
    logic                wr_fire, rd_beat, tile_done, load;
    logic [TILE_W-1:0]   rd_data_q;

    // Ready depends on current state only; a slot freed this edge is not reusable until next.
    assign bus.wr_ready = (mem_count_q < DEPTH_C) && !flush;
    assign wr_fire      = bus.wr_valid && bus.wr_ready;
    assign rd_beat      = rd_valid_q && bus.rd_ready;
    assign tile_done    = rd_beat && (rem_q == ONE_R);
    // Refill the output register when it is empty or its tile retires on this edge.
    assign load         = (mem_count_q != '0) && (!rd_valid_q || tile_done) && !flush;

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_valid_q && (rem_q == ONE_R);
    assign bus.rd_data  = rd_data_q;
    assign count        = count_q;
    assign almost_full  = almost_full_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_count_d = mem_count_q;
        count_d     = count_q;
        rd_valid_d  = rd_valid_q;
        rem_d       = rem_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            mem_count_d = '0;
            count_d     = '0;
            rd_valid_d  = 1'b0;
            rem_d       = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({wr_fire, load})
                2'b10:   mem_count_d = mem_count_q + 1'b1;
                2'b01:   mem_count_d = mem_count_q - 1'b1;
                default: mem_count_d = mem_count_q;
            endcase
            // A load only moves a tile between memory and output register.
            case ({wr_fire, tile_done})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (load) begin
                rd_valid_d = 1'b1;
                rem_d      = (reuse_num == '0) ? ONE_R : reuse_num;
            end else if (tile_done) begin
                rd_valid_d = 1'b0;
                rem_d      = '0;
            end else if (rd_beat) begin
                rem_d = rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_count_q   <= '0;
            count_q       <= '0;
            rd_valid_q    <= 1'b0;
            rem_q         <= '0;
            almost_full_q <= (AFULL_TH == 0);
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_count_q   <= mem_count_d;
            count_q       <= count_d;
            rd_valid_q    <= rd_valid_d;
            rem_q         <= rem_d;
            almost_full_q <= (count_d >= AFULL_C);
        end
    end

    weight_fifo_mem #(
        .WIDTH  (TILE_W),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.wr_data),
        .rd_en   (load),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data_q)
    );
endmodule

// File: doc/weight_tile_fifo.md
# weight_tile_fifo

Parametrised weight-tile buffer between weight memory and the systolic PE array, replacing the fixed 4-deep weight FIFO. It adds valid/ready handshakes on both sides, arbitrary (non-power-of-two) depth, a registered show-ahead output stage, occupancy and almost-full reporting, synchronous flush, and per-tile reuse: each tile is presented `reuse_num` times before it is popped, for weight-stationary replay across input batches.

## Interface
- `WEIGHT_BW`, 8: bits per weight.
- `NUM_PE_ROWS`, 8: PE rows per tile.
- `MATRIX_SIZE`, 8: weights per row; tile width `TILE_W = WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE`.
- `FIFO_DEPTH`, 4: memory entries; any integer ≥2.
- `AFULL_TH`, 4: `almost_full` threshold on `count`, 1..FIFO_DEPTH+1.
- `REUSE_BW`, 4: width of `reuse_num`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear.
- `reuse_num` in REUSE_BW: deliveries per tile; 0 treated as 1.
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in TILE_W: write handshake.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out TILE_W: read handshake.
- `rd_last` out 1: current beat is the final delivery of this tile.
- `count` out clog2(FIFO_DEPTH+2): tiles held (memory + output register).
- `almost_full` out 1: `count >= AFULL_TH`.

## Operation
- Storage: FIFO_DEPTH-entry memory plus one output register; total capacity FIFO_DEPTH+1.
- Write accepted when `wr_valid && wr_ready`; `wr_ready = (mem_count < FIFO_DEPTH) && !flush`, computed from current state only (no same-cycle pass-through of a freed slot).
- Pointers wrap from FIFO_DEPTH-1 to 0 by compare, not by bit overflow.
- Output register loads the head memory entry whenever it is empty, or on the same edge its current tile completes; `reuse_num` is sampled at load into a reuse counter `rem = max(reuse_num,1)`.
- Read beat = `rd_valid && rd_ready`. Each beat decrements `rem`; `rd_last = rd_valid && (rem == 1)`. On the last beat the tile is retired and the next tile loads on that edge if memory is non-empty (back-to-back, no bubble); otherwise `rd_valid` drops.
- `rd_data` is stable while `rd_valid && !rd_ready`, and across non-final beats.
- Simultaneous write and memory pop in one edge: `mem_count` unchanged, both pointers advance.
- `flush`: next edge clears pointers, counts, `rd_valid`, `rem`; write and read beats in that cycle have no effect. Priority: `rst` > `flush` > handshakes.
- Changing `reuse_num` mid-tile affects only tiles loaded later.

## Timing
- Reset values: `wr_ready` 1 (falls to 0 while `flush` is high), `rd_valid` 0, `rd_last` 0, `rd_data` 0, `count` 0, `almost_full` 0 (1 if AFULL_TH is 0).
- Latency, empty FIFO: write accepted at edge k → memory; output register loads at edge k+1; `rd_valid` high in the cycle after k+1.
- Throughput: one write and one read beat per cycle sustained.
- `count` and `almost_full` are registered and reflect all handshakes up to the previous edge.
- Reset asserted mid-operation: all state cleared asynchronously, contents discarded.

## Structure
- Package `weight_fifo_pkg`: `TILE_W` derivation, pointer/count width functions (clog2 of DEPTH and DEPTH+2).
- Sub-module `weight_fifo_mem`: simple dual-port array, one write port and one synchronous read port, no reset on the data array.
- Top: pointer and count logic, output register, reuse counter, flags.

## Test plan
- DEPTH=4, reuse_num=1: write tiles A,B,C; rd_ready=1 → A,B,C on consecutive cycles, `rd_last` high each beat; first `rd_valid` 2 edges after the write of A.
- Fill with rd_ready=0: 5 writes accepted, 6th stalls (`wr_ready`=0), `count`=5, `almost_full` high from `count`≥4; then drain all 5 in order.
- reuse_num=3, tiles A,B, rd_ready=1: sequence A,A,A,B,B,B; `rd_last` on beats 3 and 6; no bubble between A and B.
- DEPTH=3, 20 tiles streamed with random wr_valid/rd_ready: output order and data match the scoreboard across pointer wrap; no loss or duplication.
- flush with 3 tiles held and rd_valid high: next cycle `count`=0, `rd_valid`=0; a new write afterwards appears with normal 2-edge latency.
- `rst` pulsed mid-stream, asynchronously between edges: outputs return to reset values immediately; the stream restarts cleanly after release.
